seq_pattern_gen: RTL and testbench

- Serial pattern transmitter. It streams a programmable PAT_W-bit pattern MSB-first, one bit per clock, for a requested number of repetitions.
- Consecutive repetitions can optionally share their maximal prefix/suffix overlap. This lets downstream overlapping sequence detectors be stimulated with back-to-back hits.
- It sits upstream of the team's serial sequence-detector blocks, as stimulus or link source. It also serves as the reusable bit-stream source for their benches.

---
 rtl/seq_pattern_gen.sv | 157 +++++++++++++++
 tb/tb_seq_pattern_gen.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: streams a latched PAT_W-bit pattern MSB-first for
// rep_cnt repetitions, optionally sharing the prefix/suffix border between reps.
module seq_pattern_gen #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] rep_cnt,
  input  logic [GAP_W-1:0] gap,
  input  logic             overlap_en,
  output logic             data,
  output logic             data_vld,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(PAT_W - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    SEND = 3'd2,
    GAP  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [IDX_W-1:0] border, border_nxt;
  logic [CNT_W-1:0] rep_left, rep_left_nxt;
  logic [GAP_W-1:0] gap_left, gap_left_nxt;
  logic [GAP_W-1:0] gap_l, gap_l_nxt;
  logic [PAT_W-1:0] pat, pat_nxt;
  logic             ovl_l, ovl_l_nxt;
  logic             data_nxt, vld_nxt, busy_nxt, done_nxt;

  // Largest b in 0..PAT_W-1 whose top b bits equal its bottom b bits.
  function automatic logic [IDX_W-1:0] border_of(input logic [PAT_W-1:0] p);
    logic [IDX_W-1:0] b;
    logic             match;
    b = '0;
    for (int k = 1; k < PAT_W; k++) begin
      match = 1'b1;
      for (int i = 0; i < k; i++) begin
        if (p[PAT_W-k+i] != p[i]) match = 1'b0;
      end
      if (match) b = IDX_W'(k);
    end
    return b;
  endfunction

  always_comb begin
    state_nxt    = state;
    idx_nxt      = idx;
    border_nxt   = border;
    rep_left_nxt = rep_left;
    gap_left_nxt = gap_left;
    gap_l_nxt    = gap_l;
    pat_nxt      = pat;
    ovl_l_nxt    = ovl_l;

    case (state)
      IDLE: begin
        if (start) begin
          if (rep_cnt != '0) begin
            pat_nxt      = pattern;
            rep_left_nxt = rep_cnt;
            gap_l_nxt    = gap;
            ovl_l_nxt    = overlap_en;
            state_nxt    = LOAD;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      LOAD: begin
        border_nxt = border_of(pat);
        idx_nxt    = TOP_IDX;
        state_nxt  = SEND;
      end
      SEND: begin
        if (idx == '0) begin
          if (rep_left == CNT_W'(1)) begin
            state_nxt = DONE;
          end else begin
            rep_left_nxt = rep_left - CNT_W'(1);
            if (gap_l != '0) begin
              gap_left_nxt = gap_l;
              state_nxt    = GAP;
            end else begin
              // Back-to-back reps may skip the shared border bits.
              idx_nxt = ovl_l ? (TOP_IDX - border) : TOP_IDX;
            end
          end
        end else begin
          idx_nxt = idx - IDX_W'(1);
        end
      end
      GAP: begin
        if (gap_left == GAP_W'(1)) begin
          idx_nxt   = TOP_IDX;
          state_nxt = SEND;
        end else begin
          gap_left_nxt = gap_left - GAP_W'(1);
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Outputs are registered views of the state being entered.
    vld_nxt  = (state_nxt == SEND);
    data_nxt = vld_nxt ? pat[idx_nxt] : 1'b0;
    busy_nxt = (state_nxt == LOAD) || (state_nxt == SEND) || (state_nxt == GAP);
    done_nxt = (state_nxt == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      idx      <= '0;
      border   <= '0;
      rep_left <= '0;
      gap_left <= '0;
      gap_l    <= '0;
      pat      <= '0;
      ovl_l    <= 1'b0;
      data     <= 1'b0;
      data_vld <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      border   <= border_nxt;
      rep_left <= rep_left_nxt;
      gap_left <= gap_left_nxt;
      gap_l    <= gap_l_nxt;
      pat      <= pat_nxt;
      ovl_l    <= ovl_l_nxt;
      data     <= data_nxt;
      data_vld <= vld_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
    end
  end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Randomized bench for seq_pattern_gen against a per-cycle expected timeline
// built from the repetition/border/gap rules.
module tb_seq_pattern_gen;

  localparam int PAT_W = 4;
  localparam int CNT_W = 8;
  localparam int GAP_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [PAT_W-1:0] pattern = '0;
  logic [CNT_W-1:0] rep_cnt = '0;
  logic [GAP_W-1:0] gap = '0;
  logic             overlap_en = 1'b0;
  logic             data, data_vld, busy, done;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic d;
    logic v;
    logic b;
    logic dn;
  } exp_t;

  seq_pattern_gen #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern), .rep_cnt(rep_cnt),
    .gap(gap), .overlap_en(overlap_en), .data(data), .data_vld(data_vld),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int ref_border(input int p);
    for (int k = PAT_W - 1; k >= 1; k--)
      if ((p >> (PAT_W - k)) == (p & ((1 << k) - 1))) return k;
    return 0;
  endfunction

  task automatic randomize_inputs();
    pattern    = PAT_W'($urandom);
    rep_cnt    = CNT_W'($urandom);
    gap        = GAP_W'($urandom);
    overlap_en = 1'($urandom);
  endtask

  // One transfer: start accepted at the posedge ending cycle 0, then every
  // cycle through one idle cycle after done is compared to the timeline.
  task automatic run_xfer(input int xid, input int p, input int rep, input int g,
                          input bit ovl, input int hold);
    exp_t q[$];
    exp_t e;
    int   b, first, n, bits;
    b = ref_border(p);
    bits = 0;
    if (rep != 0) begin
      q.push_back('{d:1'b0, v:1'b0, b:1'b1, dn:1'b0});
      for (int r = 0; r < rep; r++) begin
        if (r > 0 && g > 0)
          for (int i = 0; i < g; i++) q.push_back('{d:1'b0, v:1'b0, b:1'b1, dn:1'b0});
        first = (r > 0 && g == 0 && ovl) ? (PAT_W - 1 - b) : (PAT_W - 1);
        for (int i = first; i >= 0; i--) begin
          q.push_back('{d:1'((p >> i) & 1), v:1'b1, b:1'b1, dn:1'b0});
          bits++;
        end
      end
    end
    q.push_back('{d:1'b0, v:1'b0, b:1'b0, dn:1'b1});
    q.push_back('{d:1'b0, v:1'b0, b:1'b0, dn:1'b0});
    n = q.size() - 1;
    if (rep != 0)
      check($sformatf("x%0d bitcount", xid), 32'(bits),
            32'((ovl && g == 0) ? PAT_W + (rep - 1) * (PAT_W - b) : rep * PAT_W));

    @(negedge clk);
    pattern = PAT_W'(p); rep_cnt = CNT_W'(rep); gap = GAP_W'(g); overlap_en = ovl;
    start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= q.size(); c++) begin
      @(negedge clk);
      e = q[c-1];
      check($sformatf("x%0d c%0d data", xid, c), 32'(data), 32'(e.d));
      check($sformatf("x%0d c%0d vld", xid, c), 32'(data_vld), 32'(e.v));
      check($sformatf("x%0d c%0d busy", xid, c), 32'(busy), 32'(e.b));
      check($sformatf("x%0d c%0d done", xid, c), 32'(done), 32'(e.dn));
      randomize_inputs();
      start = (c < hold && c < n) ? 1'b1 : 1'b0;
    end
    start = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst data", 32'(data), 0);
    check("rst vld", 32'(data_vld), 0);
    check("rst busy", 32'(busy), 0);
    check("rst done", 32'(done), 0);
    rst = 1'b1;

    run_xfer(1, 4'b1011, 1, 0, 1'b0, 1);
    run_xfer(2, 4'b1011, 3, 0, 1'b1, 1);
    run_xfer(3, 4'b1011, 2, 2, 1'b1, 1);
    run_xfer(4, 4'b1111, 3, 0, 1'b1, 1);
    run_xfer(5, 4'b1000, 3, 0, 1'b1, 1);
    run_xfer(6, 4'b1011, 0, 0, 1'b0, 1);
    run_xfer(7, 4'b1011, 1, 0, 1'b0, 6);
    run_xfer(8, 4'b1011, 255, 0, 1'b1, 1);
    run_xfer(9, 4'b0110, 4, 15, 1'b1, 3);

    // Asynchronous reset during SEND of a 3-rep overlapped transfer.
    @(negedge clk);
    pattern = 4'b1011; rep_cnt = 3; gap = 0; overlap_en = 1'b1; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("mid rst data", 32'(data), 0);
    check("mid rst vld", 32'(data_vld), 0);
    check("mid rst busy", 32'(busy), 0);
    check("mid rst done", 32'(done), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("in rst %0d done", i), 32'(done), 0);
      check($sformatf("in rst %0d busy", i), 32'(busy), 0);
    end
    rst = 1'b1;
    @(negedge clk);
    check("post rst done", 32'(done), 0);
    run_xfer(10, 4'b1011, 1, 0, 1'b0, 1);

    for (int t = 0; t < 40; t++)
      run_xfer(100 + t, int'($urandom_range(0, 15)), int'($urandom_range(0, 6)),
               int'($urandom_range(0, 3)), 1'($urandom), int'($urandom_range(1, 8)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

endmodule
